// File: rtl/ip_cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ip_cu_pkg
//  Purpose  : Shared encodings for the Calculation Unit sequencing controller:
//             FSM state codes, host opcodes and datapath one-hot op selects.
//  Revision : 1.0  initial release
// ============================================================================
package ip_cu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t OP_IDLE = 3'd0;
    localparam state_t OP_INI  = 3'd1;
    localparam state_t OP_CAL  = 3'd2;
    localparam state_t OP_RDY  = 3'd3;
    localparam state_t OP_HALT = 3'd4;

    typedef logic [1:0] opcode_t;

    localparam opcode_t CU_ADD = 2'd0;
    localparam opcode_t CU_SUB = 2'd1;
    localparam opcode_t CU_MUL = 2'd2;
    localparam opcode_t CU_DIV = 2'd3;

    // Bit order follows the datapath op_sel bus {div,mul,sub,add}
    typedef logic [3:0] op_sel_t;

    localparam op_sel_t c_sel_none = 4'b0000;
    localparam op_sel_t c_sel_add  = 4'b0001;
    localparam op_sel_t c_sel_sub  = 4'b0010;
    localparam op_sel_t c_sel_mul  = 4'b0100;
    localparam op_sel_t c_sel_div  = 4'b1000;

    function automatic op_sel_t op_decode(input opcode_t op);
        op_sel_t sel;
        case (op)
            CU_ADD:  sel = c_sel_add;
            CU_SUB:  sel = c_sel_sub;
            CU_MUL:  sel = c_sel_mul;
            default: sel = c_sel_div;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_cu_itcnt.sv
`default_nettype none
// ============================================================================
//  Module   : ip_cu_itcnt
//  Purpose  : Loadable down-counter tracking MUL/DIV shift-add iterations.
//  Revision : 1.0  initial release
// ============================================================================
module ip_cu_itcnt #(
    parameter int CNT_SZ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CNT_SZ-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [CNT_SZ-1:0] r_cnt_q;
    logic [CNT_SZ-1:0] w_cnt_d;

    // Load wins over decrement; decrement saturates at zero
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (load) begin
            w_cnt_d = load_val;
        end else if (dec && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ip_cu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ip_cu_ctrl
//  Purpose  : CU sequencing controller - host handshake, op enable decode,
//             state strobes and MUL/DIV iteration sequencing with abort.
//  Revision : 1.0  initial release
// ============================================================================
module ip_cu_ctrl
    import ip_cu_pkg::*;
#(
    parameter int ALU_SZ = 8,
    parameter int EXD_SZ = 1
) (
    input  logic       pclk,
    input  logic       prst,
    input  logic       cu_req,
    input  logic [1:0] cu_op,
    input  logic       cu_abort,
    output logic       cu_ack,
    output logic       cu_busy,
    output logic       cu_done,
    output logic       add_en,
    output logic       sub_en,
    output logic       mul_en,
    output logic       div_en,
    output logic       op_ini_sm,
    output logic       op_act_sm,
    output logic       op_rdy_sm,
    output logic       op_halt_sm
);

    localparam int NUM0_SZ = ALU_SZ + EXD_SZ;
    localparam int CNT_SZ  = $clog2(NUM0_SZ + 1);

    // Counter is loaded with N-1 so OP_CAL spans exactly N cycles ending at 0
    localparam logic [CNT_SZ-1:0] c_mul_load = CNT_SZ'(ALU_SZ - 1);
    localparam logic [CNT_SZ-1:0] c_div_load = CNT_SZ'(NUM0_SZ - 1);

    state_t            r_state_q;
    state_t            w_state_d;
    op_sel_t           r_en_q;
    op_sel_t           w_en_d;
    logic              r_busy_q;
    logic              w_busy_d;
    logic              r_done_q;
    logic              w_done_d;
    logic              w_ack;
    logic              w_cnt_load;
    logic [CNT_SZ-1:0] w_cnt_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    ip_cu_itcnt #(
        .CNT_SZ (CNT_SZ)
    ) u_itcnt (
        .clk      (pclk),
        .rst      (prst),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_en_d     = r_en_q;
        w_ack      = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;

        case (r_state_q)
            OP_IDLE: begin
                w_en_d = c_sel_none;
                if (cu_req && !cu_abort) begin
                    w_ack     = 1'b1;
                    w_en_d    = op_decode(cu_op);
                    w_state_d = OP_INI;
                end
            end
            OP_INI: begin
                if (cu_abort) begin
                    w_state_d  = OP_HALT;
                    w_en_d     = c_sel_none;
                    w_cnt_load = 1'b1;
                end else if ((r_en_q & (c_sel_mul | c_sel_div)) != c_sel_none) begin
                    w_state_d  = OP_CAL;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = (r_en_q == c_sel_div) ? c_div_load : c_mul_load;
                end else begin
                    w_state_d = OP_RDY;
                end
            end
            OP_CAL: begin
                w_cnt_dec = 1'b1;
                if (cu_abort) begin
                    w_state_d  = OP_HALT;
                    w_en_d     = c_sel_none;
                    w_cnt_load = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_d = OP_RDY;
                end
            end
            OP_RDY: begin
                // Abort is deliberately ignored here; the result is already valid
                w_state_d = OP_IDLE;
                w_en_d    = c_sel_none;
            end
            OP_HALT: begin
                w_en_d = c_sel_none;
                if (!cu_abort) begin
                    w_state_d = OP_IDLE;
                end
            end
            default: begin
                w_state_d = OP_IDLE;
                w_en_d    = c_sel_none;
            end
        endcase

        w_busy_d = (w_state_d != OP_IDLE);
        w_done_d = (r_state_q == OP_RDY);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state_q <= OP_IDLE;
            r_en_q    <= c_sel_none;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_en_q    <= w_en_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign cu_ack     = w_ack;
    assign cu_busy    = r_busy_q;
    assign cu_done    = r_done_q;
    assign add_en     = r_en_q[0];
    assign sub_en     = r_en_q[1];
    assign mul_en     = r_en_q[2];
    assign div_en     = r_en_q[3];
    assign op_ini_sm  = (r_state_q == OP_INI);
    assign op_act_sm  = (r_state_q == OP_INI) || (r_state_q == OP_CAL) || (r_state_q == OP_RDY);
    assign op_rdy_sm  = (r_state_q == OP_RDY);
    assign op_halt_sm = (r_state_q == OP_HALT);

    a_en_onehot: assert property (@(posedge pclk) disable iff (prst) $onehot0(r_en_q));

endmodule
`default_nettype wire

// File: tb/tb_ip_cu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_cu_ctrl
//  Purpose  : Scoreboard bench for ip_cu_ctrl: directed ops, aborts,
//             collisions, mid-op reset and a random op/abort soak.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ip_cu_ctrl;

    logic       pclk;
    logic       prst;
    logic       cu_req;
    logic [1:0] cu_op;
    logic       cu_abort;
    logic       cu_ack;
    logic       cu_busy;
    logic       cu_done;
    logic       add_en;
    logic       sub_en;
    logic       mul_en;
    logic       div_en;
    logic       op_ini_sm;
    logic       op_act_sm;
    logic       op_rdy_sm;
    logic       op_halt_sm;

    ip_cu_ctrl #(
        .ALU_SZ (8),
        .EXD_SZ (1)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .cu_req     (cu_req),
        .cu_op      (cu_op),
        .cu_abort   (cu_abort),
        .cu_ack     (cu_ack),
        .cu_busy    (cu_busy),
        .cu_done    (cu_done),
        .add_en     (add_en),
        .sub_en     (sub_en),
        .mul_en     (mul_en),
        .div_en     (div_en),
        .op_ini_sm  (op_ini_sm),
        .op_act_sm  (op_act_sm),
        .op_rdy_sm  (op_rdy_sm),
        .op_halt_sm (op_halt_sm)
    );

    typedef struct {
        logic [3:0] sel;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         rnd_mode = 0;
    logic [3:0] last_sel = 4'b0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // {ini,act,rdy,halt,div,mul,sub,add,busy,done}
    function automatic logic [9:0] get_vec();
        return {op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
                div_en, mul_en, sub_en, add_en, cu_busy, cu_done};
    endfunction

    // Cycle k after the ack cycle for an op with lat OP_CAL cycles
    function automatic logic [9:0] exp_vec(input int k, input int lat, input logic [3:0] sel);
        if (k == 1)             return {4'b1100, sel, 2'b10};
        else if (k <= lat + 1)  return {4'b0100, sel, 2'b10};
        else if (k == lat + 2)  return {4'b0110, sel, 2'b10};
        else                    return 10'b00_0000_0001;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return (op == 2'd2) ? 8 : (op == 2'd3) ? 9 : 0;
    endfunction

    function automatic logic [3:0] sel_of(input logic [1:0] op);
        logic [3:0] one;
        one = 4'b0001;
        return one << op;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Raise a request and wait (bounded) for the ack; optionally expect a done
    task automatic issue(input logic [1:0] op, input bit push, output int t);
        bit got;
        got = 0;
        tick();
        cu_req = 1'b1;
        cu_op  = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (cu_ack) begin
                got = 1;
                break;
            end
            tick();
        end
        chk("ack", {31'b0, got}, 32'd1);
        t = cyc;
        if (push && got) sb.push_back('{sel: sel_of(op), cyc: t + 3 + lat_of(op)});
    endtask

    task automatic run_op(input logic [1:0] op);
        int t;
        issue(op, 1, t);
        for (int k = 1; k <= lat_of(op) + 3; k++) begin
            tick();
            if (k == 1) cu_req = 1'b0;
            @(negedge pclk);
            chk($sformatf("seq_op%0d_k%0d", op, k), {22'b0, get_vec()},
                {22'b0, exp_vec(k, lat_of(op), sel_of(op))});
        end
    endtask

    // Scoreboard monitor: every cu_done must match the oldest expected op
    always @(negedge pclk) begin
        if (!prst && cu_done && !rnd_mode) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cycle %0d got cu_done=1 required 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_op", {28'b0, last_sel}, {28'b0, e.sel});
            end
        end
        if (op_rdy_sm) last_sel = {div_en, mul_en, sub_en, add_en};
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        prst     = 1'b1;
        cu_req   = 1'b0;
        cu_op    = 2'd0;
        cu_abort = 1'b0;
        repeat (2) @(negedge pclk);
        chk("reset_vec", {22'b0, get_vec()}, 32'd0);
        chk("reset_ack", {31'b0, cu_ack}, 32'd0);
        tick();
        prst = 1'b0;

        // Directed ADD/SUB/MUL/DIV sequences
        run_op(2'd0);
        run_op(2'd1);
        run_op(2'd2);
        run_op(2'd3);

        // Abort MUL on the 4th OP_CAL cycle for 3 cycles
        issue(2'd2, 0, t);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) cu_req = 1'b0;
            if (k == 5) cu_abort = 1'b1;
            if (k == 8) cu_abort = 1'b0;
            @(negedge pclk);
            if (k <= 5)
                chk($sformatf("abort_k%0d", k), {22'b0, get_vec()}, {22'b0, exp_vec(k, 8, 4'b0100)});
            else if (k <= 8)
                chk($sformatf("abort_halt_k%0d", k), {22'b0, get_vec()}, {22'b0, 10'b0001_0000_10});
            else
                chk("abort_idle", {22'b0, get_vec()}, 32'd0);
        end
        run_op(2'd0);

        // Request held during MUL OP_CAL is acked only in the cu_done cycle
        issue(2'd2, 1, t);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) cu_req = 1'b0;
            if (k == 3) begin
                cu_req = 1'b1;
                cu_op  = 2'd0;
            end
            @(negedge pclk);
            if (k >= 3) chk($sformatf("coll_ack_k%0d", k), {31'b0, cu_ack}, {31'b0, (k == 11)});
        end
        if (cu_ack) sb.push_back('{sel: 4'b0001, cyc: cyc + 3});
        tick();
        cu_req = 1'b0;
        repeat (4) tick();

        // Abort in idle blocks a simultaneous request
        cu_req   = 1'b1;
        cu_op    = 2'd1;
        cu_abort = 1'b1;
        @(negedge pclk);
        chk("idle_abort_ack", {31'b0, cu_ack}, 32'd0);
        tick();
        cu_req   = 1'b0;
        cu_abort = 1'b0;
        @(negedge pclk);
        chk("idle_abort_vec", {22'b0, get_vec()}, 32'd0);

        // Abort during OP_RDY is ignored
        issue(2'd0, 1, t);
        tick();
        cu_req = 1'b0;
        tick();
        cu_abort = 1'b1;
        @(negedge pclk);
        chk("rdy_abort_rdy", {31'b0, op_rdy_sm}, 32'd1);
        tick();
        cu_abort = 1'b0;
        @(negedge pclk);
        chk("rdy_abort_vec", {22'b0, get_vec()}, 32'd1);

        // Reset in the middle of DIV OP_CAL
        issue(2'd3, 0, t);
        tick();
        cu_req = 1'b0;
        repeat (3) tick();
        @(negedge pclk);
        chk("rst_pre_cal", {22'b0, get_vec()}, {22'b0, exp_vec(4, 9, 4'b1000)});
        tick();
        prst = 1'b1;
        tick();
        @(negedge pclk);
        chk("rst_mid_vec", {22'b0, get_vec()}, 32'd0);
        chk("rst_mid_ack", {31'b0, cu_ack}, 32'd0);
        prst = 1'b0;
        repeat (15) tick();

        // Random op/abort soak
        rnd_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            cu_req   = ($urandom_range(0, 2) == 0);
            cu_op    = 2'($urandom_range(0, 3));
            cu_abort = ($urandom_range(0, 7) == 0);
            @(negedge pclk);
            chk("rnd_onehot", {31'b0, $onehot0({div_en, mul_en, sub_en, add_en})}, 32'd1);
            chk("rnd_busy", {31'b0, cu_busy}, {31'b0, op_act_sm | op_halt_sm});
            chk("rnd_ack", {31'b0, cu_ack},
                {31'b0, cu_req & ~cu_abort & ~(op_act_sm | op_halt_sm)});
        end
        tick();
        cu_req   = 1'b0;
        cu_abort = 1'b0;
        repeat (20) tick();
        rnd_mode = 0;

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
